// File: rtl/cbus_ram_responder_pkg.sv
// Cache-bus types and the responder state encoding.
// Shared by the RAM responder and anything that talks to it.
package cbus_ram_responder_pkg;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } cbus_size_t;

   // The encoding is the beat count minus one.
   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } cbus_len_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      cbus_size_t  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      cbus_len_t   len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   typedef logic [1:0] cbus_resp_state_t;

   localparam cbus_resp_state_t RS_IDLE  = 2'd0;
   localparam cbus_resp_state_t RS_WAIT  = 2'd1;
   localparam cbus_resp_state_t RS_BURST = 2'd2;

   function automatic logic [4:0] beat_count(input cbus_len_t len);
      case (len)
         MLEN1:   beat_count = 5'd1;
         MLEN2:   beat_count = 5'd2;
         MLEN4:   beat_count = 5'd4;
         MLEN8:   beat_count = 5'd8;
         MLEN16:  beat_count = 5'd16;
         default: beat_count = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/cbus_ram_responder_lutram.sv
// Word-wide distributed RAM: byte-strobed synchronous write, combinational read.
// Contents are deliberately not reset.
module cbus_ram_responder_lutram #(
   parameter int NUM_BYTES = 65536
) (
   input  logic                           clk,
   input  logic                           write_en,
   input  logic [$clog2(NUM_BYTES)-1:2]   index,
   input  logic [3:0]                     strobe,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [NUM_BYTES/4];

   always_ff @(posedge clk) begin
      if (write_en) begin
         for (int i = 0; i < 4; i++) begin
            if (strobe[i]) begin
               mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[index];

endmodule

// File: rtl/cbus_ram_responder.sv
// Cache-bus responder backed by an on-chip word RAM, with a programmable
// first-beat latency and an external stall input for back-pressure testing.
module cbus_ram_responder
   import cbus_ram_responder_pkg::*;
#(
   parameter int MEM_BYTES = 65536,
   parameter int LATENCY   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp,
   input  logic       stall,
   output logic       busy
);

   localparam int         AW       = $clog2(MEM_BYTES);
   localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

   cbus_resp_state_t state;
   logic [3:0]       beat;
   logic [3:0]       lat_cnt;
   logic [AW-1:0]    base_addr;
   logic             is_write_q;
   cbus_len_t        len_q;

   logic [AW-1:0]    beat_addr;
   logic [31:0]      rdata;
   logic             ready;
   logic             last_beat;
   logic             write_en;

   // Truncation to AW bits makes bursts wrap past the top of RAM to word 0.
   assign beat_addr = base_addr + AW'({beat, 2'b00});
   assign ready     = (state == RS_BURST) && !stall;
   assign last_beat = ({1'b0, beat} + 5'd1) == beat_count(len_q);
   assign write_en  = ready && creq.valid && is_write_q;
   assign busy      = (state != RS_IDLE);

   always_comb begin
      cresp.ready = ready;
      cresp.last  = ready && last_beat;
      cresp.data  = (ready && !is_write_q) ? rdata : 32'h0;
   end

   // Dropping valid in WAIT or BURST abandons the transaction on the next edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RS_IDLE;
         beat       <= '0;
         lat_cnt    <= '0;
         base_addr  <= '0;
         is_write_q <= 1'b0;
         len_q      <= MLEN1;
      end else begin
         case (state)
            RS_IDLE: begin
               if (creq.valid) begin
                  base_addr  <= {creq.addr[AW-1:2], 2'b00};
                  is_write_q <= creq.is_write;
                  len_q      <= creq.len;
                  beat       <= '0;
                  if (LATENCY == 0) begin
                     state <= RS_BURST;
                  end else begin
                     state   <= RS_WAIT;
                     lat_cnt <= LAT_INIT;
                  end
               end
            end
            RS_WAIT: begin
               if (!creq.valid) begin
                  state <= RS_IDLE;
               end else if (lat_cnt == 4'd0) begin
                  state <= RS_BURST;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            RS_BURST: begin
               if (!creq.valid) begin
                  state <= RS_IDLE;
               end else if (ready) begin
                  beat <= beat + 4'd1;
                  if (last_beat) begin
                     state <= RS_IDLE;
                  end
               end
            end
            default: state <= RS_IDLE;
         endcase
      end
   end

   cbus_ram_responder_lutram #(
      .NUM_BYTES(MEM_BYTES)
   ) u_ram (
      .clk      (clk),
      .write_en (write_en),
      .index    (beat_addr[AW-1:2]),
      .strobe   (creq.strobe),
      .wdata    (creq.data),
      .rdata    (rdata)
   );

endmodule
